pc_src_sequencer: RTL and testbench

- Multicycle controller that drives the PC-source mux selector and the PC/EPC write strobes for each instruction.
- Resolves normal PC updates: sequential, branch, jump, jump-register, return-from-exception, and memory-indirect.
- Runs the exception sequence: save EPC, read the vector byte at 253/254/255, load PC from the sign-extended byte.
- Sits between the main control FSM (start/class/flags) and the PC-source mux, PC register, EPC register and the memory address mux.

---
 rtl/pc_src_if.sv | 30 +++
 rtl/pc_src_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_src_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_src_if.sv
// Handshake/bus between the main control FSM and the PC-source sequencer.
// The master side issues start/class/flags; the slave side drives mux select and strobes.
interface pc_src_if #(
    parameter int SEL_W = 3
);
    logic             start;
    logic [2:0]       instr_class;
    logic             branch_cond;
    logic             exc_opcode;
    logic             exc_ovf;
    logic             exc_div0;
    logic [SEL_W-1:0] pc_src_sel;
    logic             pc_write;
    logic             epc_write;
    logic             exc_mem_read;
    logic [1:0]       exc_code;
    logic             busy;
    logic             done;
    logic             exc_taken;

    modport master (
        output start, instr_class, branch_cond, exc_opcode, exc_ovf, exc_div0,
        input  pc_src_sel, pc_write, epc_write, exc_mem_read, exc_code, busy, done, exc_taken
    );

    modport slave (
        input  start, instr_class, branch_cond, exc_opcode, exc_ovf, exc_div0,
        output pc_src_sel, pc_write, epc_write, exc_mem_read, exc_code, busy, done, exc_taken
    );
endinterface

// File: rtl/pc_src_sequencer.sv
// Multicycle PC-source controller: resolves normal PC updates and runs the
// exception sequence (save EPC, fetch vector byte, load PC).
module pc_src_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int SEL_W   = 3
) (
    input  logic     clk,
    input  logic     reset,
    pc_src_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, RESOLVE, EXC_EPC, EXC_READ, EXC_WAIT, EXC_LOAD, DONE
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_q, state_d;
    logic [2:0] cls_q, cls_d;
    logic       cond_q, cond_d;
    logic [1:0] code_q, code_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] code_in;

    logic [2:0] sel_d;
    logic       pcw_d, epc_d, mrd_d, busy_d, done_d, taken_d;
    logic [1:0] xcode_d;

    logic [SEL_W-1:0] sel_q;
    logic             pcw_q, epc_q, mrd_q, busy_q, done_q, taken_q;
    logic [1:0]       xcode_q;

    function automatic logic [2:0] resolve_sel(input logic [2:0] cls, input logic cond);
        case (cls)
            3'b001:  return cond ? 3'b001 : 3'b000;
            3'b010:  return 3'b010;
            3'b011:  return 3'b001;
            3'b100:  return 3'b011;
            3'b101:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Reserved classes are folded into the invalid-opcode exception.
    always_comb begin
        if (bus.exc_opcode || bus.instr_class[2:1] == 2'b11) code_in = 2'b01;
        else if (bus.exc_ovf)                                code_in = 2'b10;
        else if (bus.exc_div0)                               code_in = 2'b11;
        else                                                 code_in = 2'b00;
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cond_d  = cond_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                cls_d   = bus.instr_class;
                cond_d  = bus.branch_cond;
                code_d  = code_in;
                state_d = (code_in != 2'b00) ? EXC_EPC : RESOLVE;
            end
            RESOLVE:  state_d = DONE;
            EXC_EPC:  state_d = EXC_READ;
            EXC_READ: begin
                cnt_d   = LAT;
                state_d = (LAT == 4'd0) ? EXC_LOAD : EXC_WAIT;
            end
            EXC_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = EXC_LOAD;
            end
            EXC_LOAD: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        sel_d   = 3'b000;
        pcw_d   = 1'b0;
        epc_d   = 1'b0;
        mrd_d   = 1'b0;
        xcode_d = 2'b00;
        busy_d  = (state_d != IDLE);
        done_d  = 1'b0;
        taken_d = 1'b0;
        case (state_d)
            RESOLVE: begin
                sel_d = resolve_sel(cls_d, cond_d);
                pcw_d = !(cls_d == 3'b001 && !cond_d);
            end
            EXC_EPC: begin
                epc_d   = 1'b1;
                xcode_d = code_d;
            end
            EXC_READ: begin
                mrd_d   = 1'b1;
                xcode_d = code_d;
            end
            EXC_WAIT: xcode_d = code_d;
            EXC_LOAD: begin
                sel_d = 3'b100;
                pcw_d = 1'b1;
            end
            DONE: begin
                done_d  = 1'b1;
                taken_d = (code_d != 2'b00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cls_q   <= 3'b000;
            cond_q  <= 1'b0;
            code_q  <= 2'b00;
            cnt_q   <= 4'd0;
            sel_q   <= '0;
            pcw_q   <= 1'b0;
            epc_q   <= 1'b0;
            mrd_q   <= 1'b0;
            xcode_q <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cond_q  <= cond_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            sel_q   <= SEL_W'(sel_d);
            pcw_q   <= pcw_d;
            epc_q   <= epc_d;
            mrd_q   <= mrd_d;
            xcode_q <= xcode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            taken_q <= taken_d;
        end
    end

    assign bus.pc_src_sel   = sel_q;
    assign bus.pc_write     = pcw_q;
    assign bus.epc_write    = epc_q;
    assign bus.exc_mem_read = mrd_q;
    assign bus.exc_code     = xcode_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.exc_taken    = taken_q;
endmodule

// File: tb/tb_pc_src_sequencer.sv
// Scoreboard bench: two sequencers (MEM_LAT=1 and MEM_LAT=0) share random stimulus;
// a per-sequence expected timeline is queued at start and a negedge monitor checks every cycle.
module tb_pc_src_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic start, cond, op, ovf, div0;
    logic [2:0] cls;

    always #5 clk = ~clk;

    pc_src_if #(.SEL_W(3)) u_if0 ();
    pc_src_if #(.SEL_W(3)) u_if1 ();

    assign u_if0.start = start;  assign u_if1.start = start;
    assign u_if0.instr_class = cls;  assign u_if1.instr_class = cls;
    assign u_if0.branch_cond = cond; assign u_if1.branch_cond = cond;
    assign u_if0.exc_opcode = op;    assign u_if1.exc_opcode = op;
    assign u_if0.exc_ovf = ovf;      assign u_if1.exc_ovf = ovf;
    assign u_if0.exc_div0 = div0;    assign u_if1.exc_div0 = div0;

    pc_src_sequencer #(.MEM_LAT(1), .SEL_W(3)) u_dut0 (.clk(clk), .reset(reset), .bus(u_if0.slave));
    pc_src_sequencer #(.MEM_LAT(0), .SEL_W(3)) u_dut1 (.clk(clk), .reset(reset), .bus(u_if1.slave));

    // {sel, pc_write, epc_write, mem_read, code, busy, done, exc_taken}
    logic [10:0] obs0, obs1;
    assign obs0 = {u_if0.pc_src_sel, u_if0.pc_write, u_if0.epc_write, u_if0.exc_mem_read,
                   u_if0.exc_code, u_if0.busy, u_if0.done, u_if0.exc_taken};
    assign obs1 = {u_if1.pc_src_sel, u_if1.pc_write, u_if1.epc_write, u_if1.exc_mem_read,
                   u_if1.exc_code, u_if1.busy, u_if1.done, u_if1.exc_taken};

    typedef struct {
        logic       exc;
        logic [1:0] code;
        logic [2:0] sel;
        logic       npcw;
        int         lat;
        int         pcw_cyc;
        int         done_cyc;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    rec_t cur[2];
    bit   trk[2];
    int   cyc[2];
    int   errors = 0;
    int   checks = 0;

    function automatic rec_t make_rec(input logic [2:0] c, input logic bc, input logic fo,
                                      input logic fv, input logic fd, input int lat);
        rec_t r;
        logic rsv = (c >= 3'd6);
        r.exc  = fo | fv | fd | rsv;
        r.code = (fo | rsv) ? 2'd1 : fv ? 2'd2 : fd ? 2'd3 : 2'd0;
        case (c)
            3'd1:    r.sel = bc ? 3'd1 : 3'd0;
            3'd2:    r.sel = 3'd2;
            3'd3:    r.sel = 3'd1;
            3'd4:    r.sel = 3'd3;
            3'd5:    r.sel = 3'd5;
            default: r.sel = 3'd0;
        endcase
        r.npcw = 1'b1;
        if (c == 3'd1 && !bc) r.npcw = 1'b0;
        if (r.exc) begin
            r.sel  = 3'd4;
            r.npcw = 1'b1;
        end
        r.lat      = lat;
        r.pcw_cyc  = r.exc ? 3 + lat : 1;
        r.done_cyc = r.exc ? 4 + lat : 2;
        return r;
    endfunction

    function automatic logic [10:0] exp_vec(input rec_t r, input int c);
        logic       pw, dn;
        logic [2:0] s;
        logic [1:0] cd;
        pw = (c == r.pcw_cyc) && r.npcw;
        s  = pw ? r.sel : 3'd0;
        cd = (r.exc && c <= 2 + r.lat) ? r.code : 2'd0;
        dn = (c == r.done_cyc);
        return {s, pw, r.exc && c == 1, r.exc && c == 2, cd, 1'b1, dn, dn && r.exc};
    endfunction

    task automatic chk(input string nm, input int k, input int c, input logic [10:0] got,
                       input logic [10:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%b expected=%b", nm, k, c, got, want);
        end
    endtask

    task automatic mon_step(input int k, input logic [10:0] o, input logic st);
        bit empty;
        if (trk[k]) begin
            cyc[k]++;
            chk("trace", k, cyc[k], o, exp_vec(cur[k], cyc[k]));
            if (cyc[k] >= cur[k].done_cyc) trk[k] = 0;
        end else begin
            chk("idle", k, 0, o, 11'd0);
            if (st) begin
                empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                checks++;
                if (empty) begin
                    errors++;
                    $display("FAIL accept dut%0d got=start_with_empty_queue expected=queued_seq", k);
                end else begin
                    cur[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
                    trk[k] = 1;
                    cyc[k] = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            trk[0] = 0;
            trk[1] = 0;
        end else begin
            mon_step(0, obs0, start);
            mon_step(1, obs1, start);
        end
    end

    task automatic run_seq(input logic [2:0] c, input logic bc, input logic fo, input logic fv,
                           input logic fd, input bit stray);
        rec_t r0, r1;
        int   sc;
        r0 = make_rec(c, bc, fo, fv, fd, 1);
        r1 = make_rec(c, bc, fo, fv, fd, 0);
        q0.push_back(r0);
        q1.push_back(r1);
        sc = stray ? int'($urandom_range(2, r1.done_cyc)) : 0;
        @(posedge clk); #1;
        start = 1'b1; cls = c; cond = bc; op = fo; ovf = fv; div0 = fd;
        for (int i = 1; i <= r0.done_cyc; i++) begin
            @(posedge clk); #1;
            start = (i == sc);
            cls   = 3'($urandom);
            {cond, op, ovf, div0} = 4'($urandom);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cls = 3'd0; cond = 1'b0; op = 1'b0; ovf = 1'b0; div0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_seq(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_seq(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_seq(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_seq(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_seq(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_seq(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_seq(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_seq(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_seq(3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        run_seq(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_seq(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        run_seq(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Reset lands in cycle 2 of an exception; the aborted sequence must leave no trace.
        q0.push_back(make_rec(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        q1.push_back(make_rec(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
        @(posedge clk); #1;
        start = 1'b1; cls = 3'd0; cond = 1'b0; op = 1'b0; ovf = 1'b1; div0 = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; ovf = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        for (int n = 0; n < 60; n++) begin
            logic [2:0] rc;
            logic rb, ro, rv, rd;
            rc = 3'($urandom);
            rb = 1'($urandom);
            ro = ($urandom_range(0, 5) == 0);
            rv = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 5) == 0);
            run_seq(rc, rb, ro, rv, rd, ($urandom_range(0, 2) == 0));
        end

        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || trk[0] || trk[1]) begin
            errors++;
            $display("FAIL drain got=q0:%0d q1:%0d trk:%0d%0d expected=all_empty",
                     q0.size(), q1.size(), trk[0], trk[1]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
